// File: rtl/dostring_pkg.sv
// Shared constants, FSM/phase enums and the fixed sine tables for the POV wand generator.
// The wave table is fixed at 40 entries and the colour table at 60 (two 30-entry halves).
package dostring_pkg;

  localparam logic [1:0] INPUT_TYPE_START = 2'd0;
  localparam logic [1:0] INPUT_TYPE_LED   = 2'd1;
  localparam logic [1:0] INPUT_TYPE_END   = 2'd2;

  localparam logic [1:0] MODE_WAVE  = 2'd0;
  localparam logic [1:0] MODE_COLOR = 2'd1;
  localparam logic [1:0] MODE_BLANK = 2'd2;
  localparam logic [1:0] MODE_WHITE = 2'd3;

  typedef enum logic [1:0] {REGION_TOP, REGION_MIDDLE, REGION_BOTTOM} region_e;
  typedef enum logic [1:0] {COLOR_ZERO, COLOR_ASC, COLOR_DESC} color_phase_e;
  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_START, ST_WAIT_HI, ST_WAIT_LO, ST_DONE} send_state_e;

  function automatic color_phase_e next_phase(input color_phase_e p);
    case (p)
      COLOR_DESC: return COLOR_ZERO;
      COLOR_ZERO: return COLOR_ASC;
      default:    return COLOR_DESC;
    endcase
  endfunction

  // Falling half-cosine 200..1; the rising half is its mirror about 200.
  function automatic logic [7:0] color_half(input logic [7:0] idx);
    logic [7:0] v;
    case (idx)
      8'd0:  v = 8'd200;  8'd1:  v = 8'd199;  8'd2:  v = 8'd198;  8'd3:  v = 8'd195;
      8'd4:  v = 8'd191;  8'd5:  v = 8'd187;  8'd6:  v = 8'd181;  8'd7:  v = 8'd174;
      8'd8:  v = 8'd167;  8'd9:  v = 8'd159;  8'd10: v = 8'd150;  8'd11: v = 8'd141;
      8'd12: v = 8'd131;  8'd13: v = 8'd121;  8'd14: v = 8'd110;  8'd15: v = 8'd100;
      8'd16: v = 8'd90;   8'd17: v = 8'd79;   8'd18: v = 8'd69;   8'd19: v = 8'd59;
      8'd20: v = 8'd50;   8'd21: v = 8'd41;   8'd22: v = 8'd33;   8'd23: v = 8'd26;
      8'd24: v = 8'd19;   8'd25: v = 8'd13;   8'd26: v = 8'd9;    8'd27: v = 8'd5;
      8'd28: v = 8'd2;    8'd29: v = 8'd1;
      default: v = 8'd0;
    endcase
    return v;
  endfunction

  function automatic logic [7:0] color_sin(input logic [7:0] idx);
    if (idx < 8'd30)      return color_half(idx);
    else if (idx < 8'd60) return 8'd200 - color_half(idx - 8'd30);
    else                  return 8'd0;
  endfunction

  function automatic logic [7:0] wave_pos(input logic [7:0] idx);
    logic [7:0] v;
    case (idx)
      8'd0:  v = 8'd20;  8'd1:  v = 8'd23;  8'd2:  v = 8'd26;  8'd3:  v = 8'd29;
      8'd4:  v = 8'd32;  8'd5:  v = 8'd34;  8'd6:  v = 8'd36;  8'd7:  v = 8'd38;
      8'd8:  v = 8'd39;  8'd9:  v = 8'd40;  8'd10: v = 8'd40;  8'd11: v = 8'd40;
      8'd12: v = 8'd39;  8'd13: v = 8'd38;  8'd14: v = 8'd36;  8'd15: v = 8'd34;
      8'd16: v = 8'd32;  8'd17: v = 8'd29;  8'd18: v = 8'd26;  8'd19: v = 8'd23;
      8'd20: v = 8'd20;  8'd21: v = 8'd17;  8'd22: v = 8'd14;  8'd23: v = 8'd11;
      8'd24: v = 8'd8;   8'd25: v = 8'd6;   8'd26: v = 8'd4;   8'd27: v = 8'd2;
      8'd28: v = 8'd1;   8'd29: v = 8'd0;   8'd30: v = 8'd0;   8'd31: v = 8'd0;
      8'd32: v = 8'd1;   8'd33: v = 8'd2;   8'd34: v = 8'd4;   8'd35: v = 8'd6;
      8'd36: v = 8'd8;   8'd37: v = 8'd11;  8'd38: v = 8'd14;  8'd39: v = 8'd17;
      default: v = 8'd0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/dostring_color_phase.sv
// One colour channel: phase register that rotates DESC->ZERO->ASC on stage wrap,
// plus the table lookup giving this channel's value at the current stage.
module dostring_color_phase
  import dostring_pkg::*;
#(
  parameter color_phase_e RESET_PHASE = COLOR_ZERO,
  parameter int unsigned  STAGE_SIZE  = 30
) (
  input  logic       dostring_clk,
  input  logic       dostring_reset,
  input  logic [7:0] i_stage,
  input  logic       i_advance,
  output logic [7:0] o_value
);

  color_phase_e r_phase;

  always_ff @(posedge dostring_clk or posedge dostring_reset) begin
    if (dostring_reset)  r_phase <= RESET_PHASE;
    else if (i_advance)  r_phase <= next_phase(r_phase);
  end

  always_comb begin
    o_value = 8'd0;
    case (r_phase)
      COLOR_DESC: o_value = color_sin(i_stage);
      COLOR_ASC:  o_value = color_sin(8'(STAGE_SIZE) + i_stage);
      default:    o_value = 8'd0;
    endcase
  end

endmodule

// File: rtl/dostring_multiwave.sv
// POV wand frame generator: START, STRING_SIZE LED words, END per frame, with 1..2 white
// sine traces over rotating colour bands, streamed to doled over its start/busy handshake.
//  state   | meaning
//  IDLE    | between frames; mode sampled on leaving
//  LOAD    | word type/RGB registered onto the outputs
//  START   | led_start pulse
//  WAIT_HI | waiting for doled to raise busy
//  WAIT_LO | waiting for busy to drop, then next word
//  DONE    | frame_done pulse, step counters advance
module dostring_multiwave
  import dostring_pkg::*;
#(
  parameter int unsigned STRING_SIZE      = 47,
  parameter int unsigned NUM_WAVES        = 1,
  parameter int unsigned WAVE2_OFFSET     = 20,
  parameter int unsigned LINE_WIDTH       = 1,
  parameter int unsigned WAND_SINE_SIZE   = 40,
  parameter int unsigned WAND_SINE_BASE   = 3,
  parameter int unsigned COLOR_STATE_SIZE = 30,
  parameter int unsigned WHITE_LEVEL      = 150,
  parameter int unsigned FRAME_DIVIDE     = 1
) (
  input  logic       dostring_clk,
  input  logic       dostring_reset,
  input  logic       enable,
  input  logic [1:0] mode,
  input  logic       doled_busy,
  output logic       led_start,
  output logic [1:0] input_type,
  output logic [7:0] red_out,
  output logic [7:0] green_out,
  output logic [7:0] blue_out,
  output logic       frame_done
);

  localparam logic [8:0] LAST_WORD = 9'(STRING_SIZE + 1);
  localparam logic [7:0] WHITE     = 8'(WHITE_LEVEL);

  send_state_e r_state, w_next;
  logic [8:0]  r_word;
  logic [1:0]  r_mode;
  logic [7:0]  r_wave_idx, r_stage, r_div;
  logic [1:0]  r_type;
  logic [7:0]  r_red, r_green, r_blue;

  logic        w_step, w_div_wrap, w_stage_wrap, w_advance;
  logic [7:0]  w_pos, w_idx1, w_mid0, w_mid1;
  logic [8:0]  w_idx1_sum;
  logic        w_hit0, w_hit1;
  region_e     w_region;
  logic [7:0]  w_top_r, w_top_g, w_top_b, w_bot_r, w_bot_g, w_bot_b;
  logic [1:0]  w_type;
  logic [7:0]  w_red, w_green, w_blue;

  always_ff @(posedge dostring_clk or posedge dostring_reset) begin
    if (dostring_reset) r_state <= ST_IDLE;
    else                r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    led_start  = 1'b0;
    frame_done = 1'b0;
    case (r_state)
      ST_IDLE:    if (enable && !doled_busy) w_next = ST_LOAD;
      ST_LOAD:    w_next = ST_START;
      ST_START:   begin led_start = 1'b1; w_next = ST_WAIT_HI; end
      ST_WAIT_HI: if (doled_busy) w_next = ST_WAIT_LO;
      ST_WAIT_LO: if (!doled_busy) w_next = (r_word == LAST_WORD) ? ST_DONE : ST_LOAD;
      ST_DONE:    begin frame_done = 1'b1; w_next = ST_IDLE; end
      default:    w_next = ST_IDLE;
    endcase
  end

  assign w_step       = (r_state == ST_DONE);
  assign w_div_wrap   = (r_div == 8'(FRAME_DIVIDE - 1));
  assign w_stage_wrap = (r_stage == 8'(COLOR_STATE_SIZE - 1));
  assign w_advance    = w_step && w_div_wrap && w_stage_wrap;

  always_ff @(posedge dostring_clk or posedge dostring_reset) begin
    if (dostring_reset) begin
      r_div      <= '0;
      r_wave_idx <= '0;
      r_stage    <= '0;
    end else if (w_step) begin
      if (w_div_wrap) begin
        r_div      <= '0;
        r_wave_idx <= (r_wave_idx == 8'(WAND_SINE_SIZE - 1)) ? 8'd0 : r_wave_idx + 8'd1;
        r_stage    <= w_stage_wrap ? 8'd0 : r_stage + 8'd1;
      end else begin
        r_div <= r_div + 8'd1;
      end
    end
  end

  // Output registers only move in LOAD, so they hold steady for doled's whole busy window.
  always_ff @(posedge dostring_clk or posedge dostring_reset) begin
    if (dostring_reset) begin
      r_word  <= '0;
      r_mode  <= MODE_WAVE;
      r_type  <= INPUT_TYPE_START;
      r_red   <= '0;
      r_green <= '0;
      r_blue  <= '0;
    end else begin
      if (r_state == ST_IDLE && w_next == ST_LOAD) begin
        r_word <= '0;
        r_mode <= mode;
      end
      if (r_state == ST_WAIT_LO && w_next == ST_LOAD) r_word <= r_word + 9'd1;
      if (r_state == ST_LOAD) begin
        r_type  <= w_type;
        r_red   <= w_red;
        r_green <= w_green;
        r_blue  <= w_blue;
      end
    end
  end

  assign w_pos      = 8'(r_word - 9'd1);
  assign w_idx1_sum = {1'b0, r_wave_idx} + 9'(WAVE2_OFFSET);
  assign w_idx1     = (w_idx1_sum >= 9'(WAND_SINE_SIZE)) ? 8'(w_idx1_sum - 9'(WAND_SINE_SIZE))
                                                         : w_idx1_sum[7:0];
  assign w_mid0     = wave_pos(r_wave_idx) + 8'(WAND_SINE_BASE);
  assign w_mid1     = wave_pos(w_idx1) + 8'(WAND_SINE_BASE);
  assign w_hit0     = ({1'b0, w_pos} >= {1'b0, w_mid0}) &&
                      ({1'b0, w_pos} <  {1'b0, w_mid0} + 9'(LINE_WIDTH));
  assign w_hit1     = (NUM_WAVES > 1) && ({1'b0, w_pos} >= {1'b0, w_mid1}) &&
                      ({1'b0, w_pos} <  {1'b0, w_mid1} + 9'(LINE_WIDTH));

  always_comb begin
    w_region = REGION_BOTTOM;
    if (w_hit0 || w_hit1)   w_region = REGION_MIDDLE;
    else if (w_pos < w_mid0) w_region = REGION_TOP;
  end

  always_comb begin
    w_type  = INPUT_TYPE_LED;
    w_red   = 8'd0;
    w_green = 8'd0;
    w_blue  = 8'd0;
    if (r_word == 9'd0) begin
      w_type = INPUT_TYPE_START;
    end else if (r_word == LAST_WORD) begin
      w_type  = INPUT_TYPE_END;
      w_red   = 8'hFF;
      w_green = 8'hFF;
      w_blue  = 8'hFF;
    end else begin
      case (r_mode)
        MODE_COLOR: begin w_red = w_top_r; w_green = w_top_g; w_blue = w_top_b; end
        MODE_BLANK: ;
        MODE_WHITE: begin w_red = WHITE; w_green = WHITE; w_blue = WHITE; end
        default: begin
          case (w_region)
            REGION_MIDDLE: begin w_red = WHITE;   w_green = WHITE;   w_blue = WHITE;   end
            REGION_TOP:    begin w_red = w_top_r; w_green = w_top_g; w_blue = w_top_b; end
            default:       begin w_red = w_bot_r; w_green = w_bot_g; w_blue = w_bot_b; end
          endcase
        end
      endcase
    end
  end

  dostring_color_phase #(.RESET_PHASE(COLOR_DESC), .STAGE_SIZE(COLOR_STATE_SIZE)) u_top_blue (
    .dostring_clk(dostring_clk), .dostring_reset(dostring_reset),
    .i_stage(r_stage), .i_advance(w_advance), .o_value(w_top_b));
  dostring_color_phase #(.RESET_PHASE(COLOR_ZERO), .STAGE_SIZE(COLOR_STATE_SIZE)) u_top_red (
    .dostring_clk(dostring_clk), .dostring_reset(dostring_reset),
    .i_stage(r_stage), .i_advance(w_advance), .o_value(w_top_r));
  dostring_color_phase #(.RESET_PHASE(COLOR_ASC), .STAGE_SIZE(COLOR_STATE_SIZE)) u_top_green (
    .dostring_clk(dostring_clk), .dostring_reset(dostring_reset),
    .i_stage(r_stage), .i_advance(w_advance), .o_value(w_top_g));
  dostring_color_phase #(.RESET_PHASE(COLOR_DESC), .STAGE_SIZE(COLOR_STATE_SIZE)) u_bot_green (
    .dostring_clk(dostring_clk), .dostring_reset(dostring_reset),
    .i_stage(r_stage), .i_advance(w_advance), .o_value(w_bot_g));
  dostring_color_phase #(.RESET_PHASE(COLOR_ZERO), .STAGE_SIZE(COLOR_STATE_SIZE)) u_bot_blue (
    .dostring_clk(dostring_clk), .dostring_reset(dostring_reset),
    .i_stage(r_stage), .i_advance(w_advance), .o_value(w_bot_b));
  dostring_color_phase #(.RESET_PHASE(COLOR_ASC), .STAGE_SIZE(COLOR_STATE_SIZE)) u_bot_red (
    .dostring_clk(dostring_clk), .dostring_reset(dostring_reset),
    .i_stage(r_stage), .i_advance(w_advance), .o_value(w_bot_r));

  assign input_type = r_type;
  assign red_out    = r_red;
  assign green_out  = r_green;
  assign blue_out   = r_blue;

endmodule

// File: tb/tb_dostring_multiwave.sv
// Bench for dostring_multiwave: doled busy model, a frame/word reference model derived from
// step counts, per-word and per-busy-cycle comparison, plus literal pins of known words.
module tb_dostring_multiwave;

  localparam int S    = 47;
  localparam int NW   = 2;
  localparam int OFF  = 20;
  localparam int LW   = 1;
  localparam int FD   = 3;
  localparam int WL   = 150;
  localparam int BASE = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic [1:0] mode = 2'd0;
  logic       doled_busy;
  logic       led_start, frame_done;
  logic [1:0] input_type;
  logic [7:0] red_out, green_out, blue_out;

  always #5 clk = ~clk;

  dostring_multiwave #(
    .STRING_SIZE(S), .NUM_WAVES(NW), .WAVE2_OFFSET(OFF), .LINE_WIDTH(LW),
    .WAND_SINE_SIZE(40), .WAND_SINE_BASE(BASE), .COLOR_STATE_SIZE(30),
    .WHITE_LEVEL(WL), .FRAME_DIVIDE(FD)
  ) dut (
    .dostring_clk(clk), .dostring_reset(rst), .enable(enable), .mode(mode),
    .doled_busy(doled_busy), .led_start(led_start), .input_type(input_type),
    .red_out(red_out), .green_out(green_out), .blue_out(blue_out), .frame_done(frame_done)
  );

  int WAVE [0:39] = '{20,23,26,29,32,34,36,38,39,40, 40,40,39,38,36,34,32,29,26,23,
                      20,17,14,11,8,6,4,2,1,0,       0,0,1,2,4,6,8,11,14,17};
  int CS [0:59] = '{200,199,198,195,191,187,181,174,167,159,150,141,131,121,110,
                    100,90,79,69,59,50,41,33,26,19,13,9,5,2,1,
                    0,1,2,5,9,13,19,26,33,41,50,59,69,79,90,
                    100,110,121,131,141,150,159,167,174,181,187,191,195,198,199};

  int checks = 0;
  int failures = 0;
  int hold_cycles = 8;
  int frames_done = 0;
  int starts_total = 0;
  int m_frame = 0;
  int m_word = 0;
  int m_mode = 0;
  logic [25:0] log_w [0:127][0:63];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int pk(input int t, input int r, input int g, input int b);
    return (t << 24) | (r << 16) | (g << 8) | b;
  endfunction

  // Phase order DESC(0) -> ZERO(1) -> ASC(2).
  function automatic int chan(input int ph, input int stg);
    case (ph)
      0:       return CS[stg];
      1:       return 0;
      default: return CS[30 + stg];
    endcase
  endfunction

  function automatic int expect_word(input int f, input int w, input int m);
    int s, widx, stg, rot, pos, mid0, mid;
    int tr, tg, tb, br, bg, bb;
    bit white;
    s    = f / FD;
    widx = s % 40;
    stg  = s % 30;
    rot  = s / 30;
    if (w == 0)     return pk(0, 0, 0, 0);
    if (w == S + 1) return pk(2, 255, 255, 255);
    if (w > S + 1)  return pk(3, 0, 0, 0);
    pos   = w - 1;
    mid0  = WAVE[widx] + BASE;
    white = 1'b0;
    for (int k = 0; k < NW; k++) begin
      mid = WAVE[(widx + k * OFF) % 40] + BASE;
      if (pos >= mid && pos < mid + LW) white = 1'b1;
    end
    tb = chan((0 + rot) % 3, stg); tr = chan((1 + rot) % 3, stg); tg = chan((2 + rot) % 3, stg);
    bg = chan((0 + rot) % 3, stg); bb = chan((1 + rot) % 3, stg); br = chan((2 + rot) % 3, stg);
    case (m)
      1: return pk(1, tr, tg, tb);
      2: return pk(1, 0, 0, 0);
      3: return pk(1, WL, WL, WL);
      default: begin
        if (white)       return pk(1, WL, WL, WL);
        if (pos < mid0)  return pk(1, tr, tg, tb);
        return pk(1, br, bg, bb);
      end
    endcase
  endfunction

  // doled: busy rises one cycle after the start pulse and stays high hold_cycles cycles.
  initial begin : doled
    doled_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (led_start && !rst) begin
        @(posedge clk); #1 doled_busy = 1'b1;
        repeat (hold_cycles) @(posedge clk);
        #1 doled_busy = 1'b0;
      end
    end
  end

  initial begin : compare
    int held;
    int got;
    int exp;
    bit hold_valid;
    bit prev_start;
    hold_valid = 1'b0;
    prev_start = 1'b0;
    held = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("reset_outputs",
            int'({led_start, input_type, red_out, green_out, blue_out, frame_done}), 0);
        m_frame = 0; m_word = 0; m_mode = int'(mode);
        hold_valid = 1'b0; prev_start = 1'b0;
        continue;
      end
      got = int'({input_type, red_out, green_out, blue_out});
      if (led_start) begin
        chk("start_one_cycle", int'(prev_start), 0);
        chk("start_while_busy", int'(doled_busy), 0);
        exp = expect_word(m_frame, m_word, m_mode);
        chk($sformatf("f%0d_w%0d_word", m_frame, m_word), got, exp);
        if (m_frame < 128 && m_word < 64) log_w[m_frame][m_word] = got[25:0];
        held = got; hold_valid = 1'b1;
        m_word++; starts_total++;
      end else if (doled_busy && hold_valid) begin
        chk("frozen_while_busy", got, held);
      end
      if (frame_done) begin
        chk($sformatf("f%0d_done_after_end", m_frame), m_word, S + 2);
        m_frame++; m_word = 0; frames_done++; m_mode = int'(mode);
      end
      prev_start = led_start;
    end
  end

  task automatic wait_frames(input int n);
    int target, budget;
    target = frames_done + n;
    budget = n * 700 + 200;
    while (frames_done < target && budget > 0) begin @(posedge clk); budget--; end
    if (frames_done < target) chk("frame_timeout", frames_done, target);
  endtask

  task automatic wait_word(input int w);
    int budget;
    budget = 1000;
    while (m_word < w && budget > 0) begin @(posedge clk); budget--; end
    if (m_word < w) chk("word_timeout", m_word, w);
  endtask

  task automatic wait_busy(input bit lvl);
    int budget;
    budget = 300;
    while (doled_busy !== lvl && budget > 0) begin @(posedge clk); budget--; end
    if (doled_busy !== lvl) chk("busy_timeout", int'(doled_busy), int'(lvl));
  endtask

  initial begin : stim
    int s0;
    #1 rst = 1'b1;
    repeat (5) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #2 enable = 1'b1;

    wait_frames(1);
    chk("f0_start_word",  int'(log_w[0][0]),  pk(0, 0, 0, 0));
    chk("f0_pos0_top",    int'(log_w[0][1]),  pk(1, 0, 0, 200));
    chk("f0_pos23_white", int'(log_w[0][24]), pk(1, 150, 150, 150));
    chk("f0_pos24_bot",   int'(log_w[0][25]), pk(1, 0, 200, 0));
    chk("f0_end_word",    int'(log_w[0][48]), pk(2, 255, 255, 255));

    wait_frames(3);
    chk("f2_pos23_white", int'(log_w[2][24]), pk(1, 150, 150, 150));
    chk("f3_pos26_white", int'(log_w[3][27]), pk(1, 150, 150, 150));
    chk("f3_pos20_white", int'(log_w[3][21]), pk(1, 150, 150, 150));

    wait_frames(87);
    chk("f30_pos43_white", int'(log_w[30][44]), pk(1, 150, 150, 150));
    chk("f30_pos3_white",  int'(log_w[30][4]),  pk(1, 150, 150, 150));
    chk("f87_pos0_top",    int'(log_w[87][1]),  pk(1, 0, 199, 1));
    chk("f90_pos0_rot",    int'(log_w[90][1]),  pk(1, 0, 200, 0));

    wait_word(10); mode = 2'd1;
    wait_frames(1);
    wait_word(10); mode = 2'd2;
    wait_frames(1);
    chk("f92_mode1_top", int'(log_w[92][24]), pk(1, 0, 200, 0));
    wait_word(10); mode = 2'd3;
    wait_frames(1);
    chk("f93_mode2_blank", int'(log_w[93][10]), pk(1, 0, 0, 0));
    wait_word(10); mode = 2'd0; enable = 1'b0;
    wait_frames(1);
    chk("f94_mode3_white", int'(log_w[94][10]), pk(1, 150, 150, 150));
    s0 = starts_total;
    repeat (60) @(posedge clk);
    chk("idle_when_disabled", starts_total, s0);
    #2 enable = 1'b1;

    wait_word(5);
    wait_busy(1'b1);
    hold_cycles = 100;
    s0 = starts_total;
    begin
      int budget;
      budget = 100;
      while (starts_total == s0 && budget > 0) begin @(posedge clk); budget--; end
      chk("long_hold_start_seen", int'(starts_total > s0), 1);
    end
    wait_busy(1'b1);
    hold_cycles = 8;
    s0 = starts_total;
    repeat (90) @(posedge clk);
    chk("no_start_during_long_busy", starts_total, s0);
    wait_frames(1);

    wait_word(11);
    repeat (2) @(posedge clk);
    @(negedge clk); #2 rst = 1'b1;
    #1;
    chk("async_reset_outputs",
        int'({led_start, input_type, red_out, green_out, blue_out, frame_done}), 0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    wait_frames(2);
    chk("post_reset_start", int'(log_w[0][0]), pk(0, 0, 0, 0));
    chk("post_reset_pos0",  int'(log_w[0][1]), pk(1, 0, 0, 200));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
